// File: rtl/payload_checker.sv
// payload_checker: AXI-Stream payload sink that verifies INC64, PRBS31 and
// STABILITY test payloads and exposes packet/byte/error statistics through
// an 8-bit register map.
module payload_checker #(
  parameter logic [3:0]  DEF_MODE = 4'd2,
  parameter logic [15:0] DEF_LEN  = 16'd0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        reg_wr_en,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_rd_en,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        locked,
  output logic        err_pulse
);

  localparam int unsigned DW  = 64;
  localparam int unsigned CW  = 32;
  localparam int unsigned BIW = 16;
  localparam int unsigned PW  = 31;

  localparam logic [3:0] MODE_INC64  = 4'd2;
  localparam logic [3:0] MODE_PRBS31 = 4'd3;
  localparam logic [3:0] MODE_STAB   = 4'd4;

  localparam logic [DW-1:0] STAB_MAGIC  = 64'hFEDCBA98_76543210;
  localparam logic [DW-1:0] STAB_CONST3 = 64'h00000780_00008080;
  localparam logic [CW-1:0] CNT_MAX     = 32'hFFFF_FFFF;

  // PRBS31 next state: x^31 + x^28 + 1, shifting towards the MSB
  function automatic logic [PW-1:0] prbs_step(input logic [PW-1:0] x);
    return {x[29:0], x[30] ^ x[27]};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  logic            tready_q;
  logic [3:0]      mode_q, mode_d;
  logic [15:0]     exp_len_q, exp_len_d;
  logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;
  logic [CW-1:0]   len_err_cnt_q, len_err_cnt_d;
  logic [DW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [DW-1:0]   last_bad_q, last_bad_d;
  logic            locked_q, locked_d;
  logic [BIW-1:0]  bi_q, bi_d;
  logic [CW-1:0]   pkt_bytes_q, pkt_bytes_d;
  logic [DW-1:0]   exp_q, exp_d;
  logic [PW-1:0]   ref_q, ref_d;
  logic [DW-1:0]   seq_q, seq_d;
  logic            seq_vld_q, seq_vld_d;
  logic            err_pulse_q, err_pulse_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;

  logic            accept;
  logic            data_err;
  logic            len_err;
  logic [CW-1:0]   beat_bytes;
  logic [CW-1:0]   pkt_total;
  logic [PW-1:0]   s_prbs;
  logic [31:0]     rd_mux;

  // only the low bits of the write data carry register fields
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata[31:16];

  assign accept = s_axis_tvalid & tready_q;

  // register read multiplexer, always sourced from pre-write state
  always_comb begin
    rd_mux = 32'hFEEDFACE;
    case (reg_addr)
      8'd0:    rd_mux = {28'd0, mode_q};
      8'd1:    rd_mux = {16'd0, exp_len_q};
      8'd10:   rd_mux = pkt_cnt_q;
      8'd11:   rd_mux = err_cnt_q;
      8'd12:   rd_mux = byte_cnt_q[31:0];
      8'd13:   rd_mux = byte_cnt_q[63:32];
      8'd14:   rd_mux = len_err_cnt_q;
      8'd15:   rd_mux = {31'd0, locked_q};
      8'd16:   rd_mux = last_bad_q[31:0];
      8'd17:   rd_mux = last_bad_q[63:32];
      default: rd_mux = 32'hFEEDFACE;
    endcase
  end

  // next-state: beat accounting, payload checking, register access
  always_comb begin
    mode_d        = mode_q;
    exp_len_d     = exp_len_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_cnt_d     = err_cnt_q;
    len_err_cnt_d = len_err_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    last_bad_d    = last_bad_q;
    locked_d      = locked_q;
    bi_d          = bi_q;
    pkt_bytes_d   = pkt_bytes_q;
    exp_d         = exp_q;
    ref_d         = ref_q;
    seq_d         = seq_q;
    seq_vld_d     = seq_vld_q;
    err_pulse_d   = 1'b0;
    rdata_d       = rdata_q;
    ack_d         = reg_rd_en;
    data_err      = 1'b0;
    len_err       = 1'b0;
    s_prbs        = s_axis_tdata[63:33];
    beat_bytes    = s_axis_tlast ? CW'(popcount8(s_axis_tkeep)) : 32'd8;
    pkt_total     = pkt_bytes_q + beat_bytes;

    if (reg_rd_en) rdata_d = rd_mux;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + DW'(beat_bytes);
      if (s_axis_tlast) begin
        pkt_cnt_d   = sat_inc(pkt_cnt_q);
        bi_d        = '0;
        pkt_bytes_d = '0;
        if ((exp_len_q != 16'd0) && (pkt_total != CW'(exp_len_q))) len_err = 1'b1;
      end else begin
        bi_d        = bi_q + 16'd1;
        pkt_bytes_d = pkt_total;
      end

      case (mode_q)
        MODE_INC64: begin
          // on a mismatch the reference resyncs to the received value
          if (locked_q && (s_axis_tdata != exp_q)) data_err = 1'b1;
          exp_d    = s_axis_tdata + 64'd1;
          locked_d = 1'b1;
        end
        MODE_PRBS31: begin
          if (s_axis_tdata[32:2] != s_prbs) data_err = 1'b1;
          if (locked_q && (s_prbs != prbs_step(ref_q))) data_err = 1'b1;
          ref_d    = s_prbs;
          locked_d = 1'b1;
        end
        MODE_STAB: begin
          locked_d = 1'b1;
          case (bi_q)
            16'd0: if (s_axis_tdata != STAB_MAGIC) data_err = 1'b1;
            16'd1: begin
              if (seq_vld_q && (s_axis_tdata != seq_q + 64'd1)) data_err = 1'b1;
              seq_d     = s_axis_tdata;
              seq_vld_d = 1'b1;
            end
            16'd3: if (s_axis_tdata != STAB_CONST3) data_err = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase

      if (data_err) begin
        err_cnt_d  = sat_inc(err_cnt_q);
        last_bad_d = s_axis_tdata;
      end
      if (len_err) len_err_cnt_d = sat_inc(len_err_cnt_q);
      err_pulse_d = data_err | len_err;
    end

    if (reg_wr_en) begin
      case (reg_addr)
        8'd0: mode_d    = reg_wdata[3:0];
        8'd1: exp_len_d = reg_wdata[15:0];
        8'd4: begin
          // clear overrides anything a same-cycle beat produced
          pkt_cnt_d     = '0;
          err_cnt_d     = '0;
          len_err_cnt_d = '0;
          byte_cnt_d    = '0;
          last_bad_d    = '0;
          locked_d      = 1'b0;
          bi_d          = '0;
          pkt_bytes_d   = '0;
          exp_d         = '0;
          ref_d         = '0;
          seq_d         = '0;
          seq_vld_d     = 1'b0;
          err_pulse_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // state register with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tready_q      <= 1'b0;
      mode_q        <= DEF_MODE;
      exp_len_q     <= DEF_LEN;
      pkt_cnt_q     <= '0;
      err_cnt_q     <= '0;
      len_err_cnt_q <= '0;
      byte_cnt_q    <= '0;
      last_bad_q    <= '0;
      locked_q      <= 1'b0;
      bi_q          <= '0;
      pkt_bytes_q   <= '0;
      exp_q         <= '0;
      ref_q         <= '0;
      seq_q         <= '0;
      seq_vld_q     <= 1'b0;
      err_pulse_q   <= 1'b0;
      rdata_q       <= 32'hDEADBEEF;
      ack_q         <= 1'b0;
    end else begin
      tready_q      <= enable;
      mode_q        <= mode_d;
      exp_len_q     <= exp_len_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_cnt_q     <= err_cnt_d;
      len_err_cnt_q <= len_err_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      last_bad_q    <= last_bad_d;
      locked_q      <= locked_d;
      bi_q          <= bi_d;
      pkt_bytes_q   <= pkt_bytes_d;
      exp_q         <= exp_d;
      ref_q         <= ref_d;
      seq_q         <= seq_d;
      seq_vld_q     <= seq_vld_d;
      err_pulse_q   <= err_pulse_d;
      rdata_q       <= rdata_d;
      ack_q         <= ack_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign locked        = locked_q;
  assign err_pulse     = err_pulse_q;
  assign reg_rdata     = rdata_q;
  assign reg_ack       = ack_q;

endmodule
